// File: rtl/ili9341_spi_tx.sv
// ILI9341 4-wire SPI byte serializer: mode 0, MSB first, one {dc, data} word per handshake.
module ili9341_spi_tx #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_dc,
  input  logic [7:0] in_data,
  output logic       done,
  output logic       busy,
  output logic       lcd_cs,
  output logic       lcd_dc,
  output logic       lcd_sclk,
  output logic       lcd_mosi
);

  localparam int unsigned DivW = $clog2(CLK_DIV) + 1;
  localparam int unsigned GapW = $clog2(CS_GAP) + 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(CS_GAP - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StShiftHi, StShiftLo, StGap} state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            cs_q, cs_d;
  logic            dc_q, dc_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            div_end;

  assign div_end = (div_q == DivLast);

  // Next-state and registered-output decode for the byte sequence.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    gap_d   = gap_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    cs_d    = cs_q;
    dc_d    = dc_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StSetup;
          shreg_d = in_data;
          dc_d    = in_dc;
          cs_d    = 1'b0;
          sclk_d  = 1'b0;
          mosi_d  = in_data[7];
          div_d   = '0;
          bit_d   = '0;
        end
      end
      StSetup: begin
        if (div_end) begin
          state_d = StShiftHi;
          sclk_d  = 1'b1;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StShiftHi: begin
        if (div_end) begin
          state_d = StShiftLo;
          sclk_d  = 1'b0;
          div_d   = '0;
          // After the last bit mosi is left alone to give the panel hold time.
          if (bit_q != 3'd7) begin
            shreg_d = {shreg_q[6:0], 1'b0};
            mosi_d  = shreg_q[6];
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StShiftLo: begin
        if (div_end) begin
          div_d = '0;
          if (bit_q == 3'd7) begin
            state_d = StGap;
            cs_d    = 1'b1;
            mosi_d  = 1'b0;
            done_d  = 1'b1;
            gap_d   = '0;
          end else begin
            state_d = StShiftHi;
            sclk_d  = 1'b1;
            bit_d   = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      div_q   <= '0;
      gap_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      cs_q    <= 1'b1;
      dc_q    <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      gap_q   <= gap_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      cs_q    <= cs_d;
      dc_q    <= dc_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign in_ready = (state_q == StIdle);
  assign done     = done_q;
  assign busy     = busy_q;
  assign lcd_cs   = cs_q;
  assign lcd_dc   = dc_q;
  assign lcd_sclk = sclk_q;
  assign lcd_mosi = mosi_q;

endmodule

// File: tb/tb_ili9341_spi_tx.sv
// Bench for ili9341_spi_tx: instance 0 at defaults, instance 1 with CLK_DIV=1, CS_GAP=3.
module tb_ili9341_spi_tx;

  localparam int NI = 2;

  function automatic int div_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic int gap_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid [NI];
  logic       ready [NI];
  logic       dcin  [NI];
  logic [7:0] din   [NI];
  logic       done  [NI];
  logic       busy  [NI];
  logic       cs    [NI];
  logic       dc    [NI];
  logic       sclk  [NI];
  logic       mosi  [NI];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ili9341_spi_tx #(.CLK_DIV(4), .CS_GAP(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(valid[0]), .in_ready(ready[0]), .in_dc(dcin[0]),
    .in_data(din[0]), .done(done[0]), .busy(busy[0]), .lcd_cs(cs[0]), .lcd_dc(dc[0]),
    .lcd_sclk(sclk[0]), .lcd_mosi(mosi[0])
  );

  ili9341_spi_tx #(.CLK_DIV(1), .CS_GAP(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(valid[1]), .in_ready(ready[1]), .in_dc(dcin[1]),
    .in_data(din[1]), .done(done[1]), .busy(busy[1]), .lcd_cs(cs[1]), .lcd_dc(dc[1]),
    .lcd_sclk(sclk[1]), .lcd_mosi(mosi[1])
  );

  int errors = 0;
  int checks = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One record per completed byte, as seen on the panel pins.
  typedef struct {
    int         inst;
    logic [7:0] bits;
    int         low;
    int         edges;
    logic       dc0;
    bit         dc_bad;
    int         done_cyc;
  } rec_t;

  rec_t       recs[$];
  int         done_cnt [NI];
  logic [7:0] mon_bits [NI];
  int         mon_low  [NI];
  int         mon_edges[NI];
  logic       mon_ps   [NI];
  logic       mon_pcs  [NI];
  logic       mon_dc0  [NI];
  bit         mon_dcbad[NI];

  // Pin monitor: collects mosi at each sclk rise while cs is low.
  initial begin
    for (int k = 0; k < NI; k++) begin
      done_cnt[k] = 0; mon_bits[k] = '0; mon_low[k] = 0; mon_edges[k] = 0;
      mon_ps[k] = 1'b0; mon_pcs[k] = 1'b1; mon_dc0[k] = 1'b0; mon_dcbad[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        if (rst_n !== 1'b1) begin
          mon_bits[k] = '0; mon_low[k] = 0; mon_edges[k] = 0;
          mon_ps[k] = 1'b0; mon_pcs[k] = 1'b1; mon_dcbad[k] = 1'b0;
        end else begin
          if (cs[k] === 1'b0) begin
            if (mon_pcs[k] === 1'b1) begin
              mon_dc0[k] = dc[k]; mon_low[k] = 0; mon_edges[k] = 0;
              mon_bits[k] = '0; mon_dcbad[k] = 1'b0;
            end
            mon_low[k]++;
            if (sclk[k] === 1'b1 && mon_ps[k] === 1'b0) begin
              mon_bits[k] = {mon_bits[k][6:0], mosi[k]};
              mon_edges[k]++;
            end
            if (dc[k] !== mon_dc0[k]) mon_dcbad[k] = 1'b1;
          end
          if (done[k] === 1'b1) begin
            done_cnt[k]++;
            recs.push_back('{k, mon_bits[k], mon_low[k], mon_edges[k], mon_dc0[k],
                             mon_dcbad[k], cyc});
          end
          mon_ps[k]  = sclk[k];
          mon_pcs[k] = cs[k];
        end
      end
    end
  end

  // Called at a negedge; returns the cycle number of the accepting edge's cycle.
  task automatic accept(input int k, input logic d_c, input logic [7:0] d, input bit keep,
                        output int t0);
    int n = 0;
    dcin[k] = d_c; din[k] = d; valid[k] = 1'b1;
    while (ready[k] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (ready[k] !== 1'b1) chk1("accept_timeout", ready[k], 1'b1);
    t0 = cyc;
    @(negedge clk);
    if (!keep) valid[k] = 1'b0;
  endtask

  // Reference: byte shifts MSB first, cs low 17*CLK_DIV cycles, done at T0+1+17*CLK_DIV.
  task automatic check_byte(input int k, input int t0, input logic d_c,
                            input logic [7:0] exp_bits);
    rec_t r;
    bit   ok = 0;
    int   idx;
    for (int n = 0; n < 400 && !ok; n++) begin
      idx = -1;
      for (int i = 0; i < recs.size(); i++) if (idx < 0 && recs[i].inst == k) idx = i;
      if (idx >= 0) begin
        r = recs[idx];
        recs.delete(idx);
        ok = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) begin
      chkn("done_timeout", 0, 1);
    end else begin
      chkn("mosi_bits", int'(r.bits), int'(exp_bits));
      chkn("cs_low_cycles", r.low, 17 * div_of(k));
      chkn("sclk_rises", r.edges, 8);
      chk1("lcd_dc_value", r.dc0, d_c);
      chk1("lcd_dc_stable", r.dc_bad, 1'b0);
      chkn("done_cycle", r.done_cyc, t0 + 1 + 17 * div_of(k));
    end
  endtask

  typedef struct {
    logic       dc;
    logic [7:0] data;
    logic [7:0] exp_bits;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int t0, t1, n, dc_before;
    bit bad;
    logic       rdc;
    logic [7:0] rdata;

    tbl[0] = '{1'b0, 8'hCB, 8'b11001011};
    tbl[1] = '{1'b1, 8'h39, 8'b00111001};
    tbl[2] = '{1'b1, 8'h2C, 8'b00101100};
    tbl[3] = '{1'b0, 8'h0F, 8'b00001111};
    tbl[4] = '{1'b1, 8'h80, 8'b10000000};

    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      valid[k] = 1'b0; dcin[k] = 1'b0; din[k] = '0;
    end

    // Reset values.
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk1("rst_cs", cs[k], 1'b1);
      chk1("rst_sclk", sclk[k], 1'b0);
      chk1("rst_mosi", mosi[k], 1'b0);
      chk1("rst_dc", dc[k], 1'b0);
      chk1("rst_done", done[k], 1'b0);
      chk1("rst_busy", busy[k], 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk1("ready_after_rst", ready[0], 1'b1);

    // Single command byte 0xCB with full cycle-by-cycle ready timing.
    dc_before = done_cnt[0];
    accept(0, tbl[0].dc, tbl[0].data, 1'b0, t0);
    chk1("dc_at_t0p1", dc[0], 1'b0);
    chk1("cs_at_t0p1", cs[0], 1'b0);
    chk1("busy_at_t0p1", busy[0], 1'b1);
    bad = 0;
    n = 0;
    while (cyc < t0 + 70 && n < 200) begin
      if (ready[0] !== 1'b0) bad = 1;
      @(negedge clk);
      n++;
    end
    chk1("ready_low_while_busy", bad, 1'b0);
    chk1("ready_at_t0p70", ready[0], 1'b1);
    check_byte(0, t0, tbl[0].dc, tbl[0].exp_bits);
    chkn("done_pulses_one_byte", done_cnt[0] - dc_before, 1);

    // Back-to-back data bytes with in_valid held high.
    accept(0, tbl[1].dc, tbl[1].data, 1'b1, t0);
    accept(0, tbl[2].dc, tbl[2].data, 1'b0, t1);
    chkn("b2b_accept_spacing", t1 - t0, 1 + 17 * 4 + 1);
    check_byte(0, t0, tbl[1].dc, tbl[1].exp_bits);
    check_byte(0, t1, tbl[2].dc, tbl[2].exp_bits);
    chk1("dc_held_after", dc[0], 1'b1);

    // Reset right after the third sclk rise of 0xA5.
    dc_before = done_cnt[0];
    accept(0, 1'b1, 8'hA5, 1'b0, t0);
    n = 0;
    while (mon_edges[0] < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk1("midrst_cs", cs[0], 1'b1);
    chk1("midrst_sclk", sclk[0], 1'b0);
    chk1("midrst_mosi", mosi[0], 1'b0);
    chk1("midrst_busy", busy[0], 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("midrst_ready", ready[0], 1'b1);
    repeat (80) @(negedge clk);
    chkn("midrst_no_done", done_cnt[0] - dc_before, 0);
    accept(0, tbl[3].dc, tbl[3].data, 1'b0, t0);
    check_byte(0, t0, tbl[3].dc, tbl[3].exp_bits);

    // Inputs change right after accept; the latched word must go out.
    accept(0, 1'b1, 8'h55, 1'b0, t0);
    din[0] = 8'hAA; dcin[0] = 1'b0;
    check_byte(0, t0, 1'b1, 8'b01010101);

    // Remaining table entries.
    for (int i = 4; i < 5; i++) begin
      accept(0, tbl[i].dc, tbl[i].data, 1'b0, t0);
      check_byte(0, t0, tbl[i].dc, tbl[i].exp_bits);
    end

    // CLK_DIV=1, CS_GAP=3: 0xFF then 0x00 back to back.
    accept(1, 1'b1, 8'hFF, 1'b1, t0);
    accept(1, 1'b1, 8'h00, 1'b0, t1);
    chkn("div1_accept_spacing", t1 - t0, 1 + 17 + 3);
    check_byte(1, t0, 1'b1, 8'hFF);
    check_byte(1, t1, 1'b1, 8'h00);

    // Random words with random idle gaps on both instances.
    for (int i = 0; i < 10; i++) begin
      int k;
      k = i % 2;
      rdc = 1'($urandom_range(0, 1));
      rdata = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      accept(k, rdc, rdata, 1'b0, t0);
      check_byte(k, t0, rdc, rdata);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ili9341_spi_tx.md
Name: ili9341_spi_tx

Overview:
- Byte serializer directly downstream of the ILI9341 command tables and command sequencer.
- Accepts one {dc, data} word per handshake and shifts it to the panel over 4-wire SPI, mode 0, MSB first.
- Drives lcd_cs, lcd_dc, lcd_sclk and lcd_mosi.
- Pulses done once per completed byte so the sequencer can advance its table index.

Parameters:
CLK_DIV, 4, system clocks per SCLK half-period (legal range >= 1)
CS_GAP, 1, clocks lcd_cs is held high between bytes (legal range >= 1)

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  word available
in_ready  output  1  block can accept a word (high only in IDLE)
in_dc  input  1  0 = command byte, 1 = data/parameter byte
in_data  input  8  byte to send
done  output  1  one-cycle pulse when a byte has fully shifted out
busy  output  1  high in any state other than IDLE
lcd_cs  output  1  panel chip select, active low
lcd_dc  output  1  panel data/command select
lcd_sclk  output  1  SPI clock, idles low
lcd_mosi  output  1  SPI data

Behaviour:
- Reset:
  - Sampled at a clk edge with rst_n=0; the state goes to IDLE.
  - Reset values: lcd_cs=1, lcd_sclk=0, lcd_mosi=0, lcd_dc=0, done=0, busy=0.
  - in_ready=1 from the first cycle after rst_n rises.
- Outputs: all lcd_* outputs, done and busy are registers. in_ready is a decode of state==IDLE.
- Accept: happens on a cycle T0 with in_valid & in_ready.
  - in_data is loaded into an 8-bit shift register.
  - in_dc is latched to lcd_dc.
  - After T0 the inputs are don't-care until the next accept.
- States:
  - IDLE: cs=1, sclk=0, mosi=0. Goes to SETUP on accept.
  - SETUP: from T0+1, for CLK_DIV cycles. cs=0, sclk=0, mosi=bit7.
  - SHIFT_HI: CLK_DIV cycles with sclk=1. The panel samples on this rising edge.
  - SHIFT_LO: CLK_DIV cycles with sclk=0.
    - Entering SHIFT_LO after bits 7..1: mosi presents the next lower bit on the same edge sclk falls.
    - Entering SHIFT_LO after bit 0: mosi holds bit 0 (hold time).
    - SHIFT_HI and SHIFT_LO alternate 8 times, tracked by a 3-bit bit counter.
  - GAP: entered after the 8th SHIFT_LO. cs=1, sclk=0, mosi=0, done=1 in the first GAP cycle only. Lasts CS_GAP cycles, then IDLE.
- Timing:
  - lcd_cs is low for exactly 17*CLK_DIV cycles per byte.
  - Exactly 8 sclk rising edges occur per byte.
  - Earliest next accept is T0 + 1 + 17*CLK_DIV + CS_GAP (70 cycles at the defaults).
- Back-to-back words: with in_valid held high, the next word is accepted on the first IDLE cycle. No extra bubble beyond GAP.
- lcd_dc holds its value through GAP and IDLE until the next accept, so it is always stable around cs edges.
- Counters:
  - Divider counter is $clog2(CLK_DIV)+1 bits and counts 0..CLK_DIV-1, then wraps.
  - Gap counter counts 0..CS_GAP-1.
  - No other arithmetic is performed.
- CLK_DIV=1: sclk toggles every cycle and every SETUP/SHIFT phase is one cycle long. The same state sequence applies.
- Reset mid-byte (any state):
  - The next edge forces reset values and discards the partial byte.
  - done is not pulsed; lcd_cs goes high immediately.
- in_valid while busy: ignored, since in_ready=0. The word must be held by the producer until accepted.

Test Plan:
1. Hold rst_n=0 for 3 cycles, then release -> during reset lcd_cs=1, lcd_sclk=0, lcd_mosi=0, lcd_dc=0, done=0, busy=0; in_ready=1 on the first cycle after release.
2. Defaults; send in_dc=0, in_data=8'hCB at T0 ->
   - lcd_dc=0 from T0+1.
   - lcd_cs low T0+1..T0+68.
   - Exactly 8 sclk rising edges, mosi sampled at them = 1,1,0,0,1,0,1,1.
   - done high only at T0+69.
   - in_ready=1 at T0+70.
3. Hold in_valid high with {1,8'h39} then {1,8'h2C} -> accepts 70 cycles apart; lcd_cs high exactly 1 cycle between bytes; lcd_dc stays 1 throughout; two done pulses; second byte samples 0,0,1,0,1,1,0,0.
4. Start byte 8'hA5; assert rst_n=0 for one cycle right after the 3rd sclk rising edge -> next edge lcd_cs=1, sclk=0, mosi=0; no done pulse; in_ready=1 the cycle after release; a new byte 8'h0F then transmits correctly.
5. CLK_DIV=1, CS_GAP=3; send 8'hFF then 8'h00 -> lcd_cs low 17 cycles per byte; sclk toggles every cycle; mosi constant 1 then constant 0; cs high exactly 3 cycles between bytes.
6. Accept 8'h55; on T0+1 change in_data to 8'hAA and in_dc to 0 with in_valid low -> the transmitted bits are still 0,1,0,1,0,1,0,1 and the original dc is held.
